sub_shift_iter: RTL and testbench



---
 rtl/sub_shift_iter.sv | 122 ++++++++++++
 tb/tb_sub_shift_iter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sub_shift_iter.sv
// AES-128 SubBytes + ShiftRows, one column per cycle through four shared S-boxes.
// ShiftRows is applied by steering each substituted byte to its shifted result slot.

module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);
    // Forward S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign s_o = SBOX[{~a_i, 3'b000} +: 8];
endmodule

module sub_shift_iter (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         out_last
);
    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

    state_t         state_q, state_d;
    logic [1:0]     col_q, col_d;
    logic [127:0]   cap_q, cap_d;
    logic [127:0]   res_q, res_d;
    logic           last_q, last_d;

    logic [NUM_LANES-1:0][7:0] sb_in;
    logic [NUM_LANES-1:0][7:0] sb_out;

    // Byte index of (row r, column col) is {col, r}; MSB-first ordering puts it at bit 8*(15-idx).
    for (genvar r = 0; r < NUM_LANES; r++) begin : g_lane
        assign sb_in[r] = cap_q[{~{col_q, 2'(r)}, 3'b000} +: 8];
        aes_sbox u_sbox (.a_i(sb_in[r]), .s_o(sb_out[r]));
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        cap_d    = cap_q;
        res_d    = res_q;
        last_d   = last_q;
        in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cap_d   = in_state;
                    last_d  = in_last;
                    col_d   = 2'd0;
                    state_d = SUB;
                end
            end
            SUB: begin
                // Input (r, c) lands in output column (c - r) mod 4.
                for (int r = 0; r < NUM_LANES; r++)
                    res_d[{~{col_q - 2'(r), 2'(r)}, 3'b000} +: 8] = sb_out[r];
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) state_d = DONE;
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        cap_d   = in_state;
                        last_d  = in_last;
                        col_d   = 2'd0;
                        state_d = SUB;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            cap_q   <= '0;
            res_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            cap_q   <= cap_d;
            res_q   <= res_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign out_state = res_q;
    assign out_last  = last_q;
endmodule

// File: tb/tb_sub_shift_iter.sv
// Directed vectors, handshake corner cases and a randomized run against a computed S-box model.

module tb_sub_shift_iter;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_state = '0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_state;
    logic         out_last;

    sub_shift_iter dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .out_last(out_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb [256];

    typedef struct {
        logic [127:0] st;
        logic         last;
        logic [127:0] exp;
    } vec_t;
    vec_t vecs [4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int k);
        logic [7:0] y = x;
        for (int j = 0; j < k; j++) y = {y[6:0], y[7]};
        return y;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s);
        logic [127:0] o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = sb[s[127-8*(r+4*((c+r)%4)) -: 8]];
        return o;
    endfunction

    // Waits for out_valid after an acceptance edge; n = cycles taken or -1 on timeout.
    task automatic wait_valid(output int n, output int bad_ready);
        n = 0;
        bad_ready = 0;
        do begin
            @(negedge clk);
            n++;
            if (!out_valid && in_ready) bad_ready++;
        end while (!out_valid && n < 20);
        if (!out_valid) n = -1;
    endtask

    task automatic present(input logic [127:0] st, input logic last);
        chk("accept_ready", 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        in_state = st;
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_state = '0;
    endtask

    task automatic run_vec(input int i);
        int n, bad;
        present(vecs[i].st, vecs[i].last);
        wait_valid(n, bad);
        chk($sformatf("latency_%0d", i), 128'(n), 128'd4);
        chk($sformatf("ready_in_sub_%0d", i), 128'(bad), 128'd0);
        chk($sformatf("state_%0d", i), out_state, vecs[i].exp);
        chk($sformatf("last_%0d", i), 128'(out_last), 128'(vecs[i].last));
        @(negedge clk);
        chk($sformatf("valid_after_hs_%0d", i), 128'(out_valid), 128'd0);
    endtask

    initial begin
        int n, bad, sent, recv, cyc;
        logic acc;
        logic [127:0] hold;
        logic [127:0] q[$];
        logic ql[$];

        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            if (a != 0)
                for (int b = 1; b < 256; b++)
                    if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sb[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end

        vecs[0] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 128'hd4bf5d30e0b452aeb84111f11e2798e5};
        vecs[1] = '{128'h0, 1'b1, {16{8'h63}}};
        vecs[2] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b0, 128'h636b6776f201ab7b30d777c5fe7c6f2b};
        vecs[3] = '{{16{8'hff}}, 1'b1, {16{8'h16}}};

        repeat (3) @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_state", out_state, 128'd0);
        chk("rst_out_last", 128'(out_last), 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) run_vec(i);

        // Backpressure: output held for 10 cycles
        out_ready = 1'b0;
        present(vecs[0].st, vecs[0].last);
        wait_valid(n, bad);
        chk("bp_latency", 128'(n), 128'd4);
        hold = out_state;
        chk("bp_state", hold, vecs[0].exp);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_valid", 128'(out_valid), 128'd1);
            chk("bp_stable", out_state, vecs[0].exp);
            chk("bp_in_ready", 128'(in_ready), 128'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 128'(out_valid), 128'd0);
        chk("bp_release_idle", 128'(in_ready), 128'd1);

        // Back-to-back with overlapped accept
        present(vecs[0].st, 1'b0);
        wait_valid(n, bad);
        chk("b2b_first", out_state, vecs[0].exp);
        chk("b2b_ready_in_done", 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        in_state = vecs[2].st;
        in_last  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_in_sub", 128'(out_valid), 128'd0);
        wait_valid(n, bad);
        chk("b2b_gap", 128'(n + 1), 128'd5);
        chk("b2b_second", out_state, vecs[2].exp);
        chk("b2b_second_last", 128'(out_last), 128'd1);
        @(negedge clk);

        // Reset after E2 of a transfer
        present(vecs[0].st, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_sub_valid", 128'(out_valid), 128'd0);
        chk("rst_sub_state", out_state, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_sub_ready", 128'(in_ready), 128'd1);

        // Reset while holding a result in DONE
        out_ready = 1'b0;
        present(vecs[3].st, 1'b1);
        wait_valid(n, bad);
        chk("rst_done_pre", 128'(out_valid), 128'd1);
        rst = 1'b1;
        #1;
        chk("rst_done_valid", 128'(out_valid), 128'd0);
        chk("rst_done_state", out_state, 128'd0);
        chk("rst_done_last", 128'(out_last), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        run_vec(0);

        // Randomized stalls against the model
        sent = 0; recv = 0; cyc = 0; acc = 1'b0;
        while (recv < 1000 && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            if (acc) begin
                in_valid = 1'b0;
                acc = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && sent < 1000 && $urandom_range(0, 2) != 0) begin
                in_state = {$urandom, $urandom, $urandom, $urandom};
                in_last  = 1'($urandom_range(0, 1));
                in_valid = 1'b1;
                q.push_back(model(in_state));
                ql.push_back(in_last);
                sent++;
            end
            #1;
            if (in_valid && in_ready) acc = 1'b1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_dup: got %h, expected no output", out_state);
                end else begin
                    chk("rand_state", out_state, q.pop_front());
                    chk("rand_last", 128'(out_last), 128'(ql.pop_front()));
                end
                recv++;
            end
        end
        chk("rand_count", 128'(recv), 128'd1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
